cbi980_codec: RTL and testbench

CBI980_CODEC -- requirements
Module: cbi980_codec

---
 rtl/cbi980_codec.sv | 148 ++++++++++++++
 tb/tb_cbi980_codec.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbi980_codec.sv
// I2S target-side codec bridge: stereo RX deserializer and TX serializer.
// Build option CBI980_CODEC_REPEAT_EN: on TX underrun resend the last frame.
module cbi980_codec #(
   parameter int WIDTH = 24
) (
   input  logic             aclk,
   input  logic             arstn,
   input  logic             i2s_sclk,
   input  logic             i2s_lrclk,
   input  logic             i2s_sdin,
   output logic             i2s_sdout,
   output logic [WIDTH-1:0] rx_left,
   output logic [WIDTH-1:0] rx_right,
   output logic             rx_valid,
   input  logic             rx_ready,
   input  logic [WIDTH-1:0] tx_left,
   input  logic [WIDTH-1:0] tx_right,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             err_ovr,
   output logic             err_unr
);

   logic [1:0]       sclk_s, lr_s, sd_s;
   logic             sclk_d;
   logic             rise, fall, lr, sd, sw, commit;
   logic             have_prev, prev_lr, aligned, left_ok;
   logic [WIDTH-1:0] bm, sh, left_w;
   logic             hold_full;
   logic [WIDTH-1:0] hold_l, hold_r, cur_r, tsh;
   logic [WIDTH-1:0] unr_l, unr_r;

`ifdef CBI980_CODEC_REPEAT_EN
   logic [WIDTH-1:0] last_l, last_r;
   assign unr_l = last_l;
   assign unr_r = last_r;
`else
   assign unr_l = '0;
   assign unr_r = '0;
`endif

   assign rise     = sclk_s[1] & ~sclk_d;
   assign fall     = ~sclk_s[1] & sclk_d;
   assign lr       = lr_s[1];
   assign sd       = sd_s[1];
   // the first rise after reset only records lrclk; it cannot be a switch
   assign sw       = rise & have_prev & (lr != prev_lr);
   assign commit   = sw & ~lr & aligned & left_ok;
   assign tx_ready = ~hold_full;

   always_ff @(posedge aclk) begin
      if (!arstn) begin
         sclk_s    <= '0;
         lr_s      <= '0;
         sd_s      <= '0;
         sclk_d    <= 1'b0;
         have_prev <= 1'b0;
         prev_lr   <= 1'b0;
         aligned   <= 1'b0;
         left_ok   <= 1'b0;
         bm        <= '0;
         sh        <= '0;
         left_w    <= '0;
         rx_left   <= '0;
         rx_right  <= '0;
         rx_valid  <= 1'b0;
         err_ovr   <= 1'b0;
         err_unr   <= 1'b0;
         hold_full <= 1'b0;
         hold_l    <= '0;
         hold_r    <= '0;
         cur_r     <= '0;
         tsh       <= '0;
         i2s_sdout <= 1'b0;
`ifdef CBI980_CODEC_REPEAT_EN
         last_l    <= '0;
         last_r    <= '0;
`endif
      end else begin
         sclk_s  <= {sclk_s[0], i2s_sclk};
         lr_s    <= {lr_s[0], i2s_lrclk};
         sd_s    <= {sd_s[0], i2s_sdin};
         sclk_d  <= sclk_s[1];
         err_ovr <= 1'b0;
         err_unr <= 1'b0;
         if (rx_valid && rx_ready)
            rx_valid <= 1'b0;
         if (rise) begin
            have_prev <= 1'b1;
            prev_lr   <= lr;
         end
         // receive: bm is a one-hot write pointer walking MSB to LSB
         if (sw) begin
            aligned <= 1'b1;
            bm      <= {1'b1, {(WIDTH-1){1'b0}}};
            sh      <= '0;
            if (lr) begin
               left_w  <= sh;
               left_ok <= aligned;
            end else begin
               left_ok <= 1'b0;
            end
            if (commit) begin
               if (rx_valid && !rx_ready) begin
                  err_ovr <= 1'b1;
               end else begin
                  rx_left  <= left_w;
                  rx_right <= sh;
                  rx_valid <= 1'b1;
               end
            end
         end else if (rise && aligned) begin
            sh <= sh | (sd ? bm : '0);
            bm <= bm >> 1;
         end
         // transmit: shifter empties to zero after WIDTH falls
         if (sw) begin
            i2s_sdout <= 1'b0;
            if (!lr) begin
               if (hold_full) begin
                  tsh       <= hold_l;
                  cur_r     <= hold_r;
                  hold_full <= 1'b0;
`ifdef CBI980_CODEC_REPEAT_EN
                  last_l    <= hold_l;
                  last_r    <= hold_r;
`endif
               end else begin
                  tsh     <= unr_l;
                  cur_r   <= unr_r;
                  err_unr <= 1'b1;
               end
            end else begin
               tsh <= cur_r;
            end
         end else if (fall) begin
            i2s_sdout <= tsh[WIDTH-1];
            tsh       <= tsh << 1;
         end
         if (tx_valid && !hold_full) begin
            hold_l    <= tx_left;
            hold_r    <= tx_right;
            hold_full <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cbi980_codec.sv
// Self-checking bench for cbi980_codec: an I2S controller model drives
// frames and a reference of expected words is compared at each check.
module tb_cbi980_codec;

   localparam int W = 24;
`ifdef CBI980_CODEC_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   logic         aclk = 1'b0;
   logic         arstn = 1'b0;
   logic         i2s_sclk = 1'b1;
   logic         i2s_lrclk = 1'b0;
   logic         i2s_sdin = 1'b0;
   logic         i2s_sdout;
   logic [W-1:0] rx_left, rx_right;
   logic         rx_valid;
   logic         rx_ready = 1'b1;
   logic [W-1:0] tx_left = '0;
   logic [W-1:0] tx_right = '0;
   logic         tx_valid = 1'b0;
   logic         tx_ready, err_ovr, err_unr;

   int total = 0;
   int bad = 0;

   // monitor state, written only by the monitor
   int             ovr_n = 0;
   int             unr_n = 0;
   int             vcyc = 0;
   int             unstable = 0;
   logic           pv = 1'b0;
   logic [2*W-1:0] pdat = '0;
   logic [2*W-1:0] got_q[$];

   always #5 aclk = ~aclk;

   cbi980_codec #(.WIDTH(W)) dut (
      .aclk(aclk), .arstn(arstn),
      .i2s_sclk(i2s_sclk), .i2s_lrclk(i2s_lrclk),
      .i2s_sdin(i2s_sdin), .i2s_sdout(i2s_sdout),
      .rx_left(rx_left), .rx_right(rx_right),
      .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_left(tx_left), .tx_right(tx_right),
      .tx_valid(tx_valid), .tx_ready(tx_ready),
      .err_ovr(err_ovr), .err_unr(err_unr)
   );

   always @(negedge aclk) begin
      if (arstn) begin
         if (err_ovr) ovr_n <= ovr_n + 1;
         if (err_unr) unr_n <= unr_n + 1;
         if (rx_valid) vcyc <= vcyc + 1;
         if (pv && rx_valid && {rx_left, rx_right} != pdat)
            unstable <= unstable + 1;
         if (rx_valid && rx_ready)
            got_q.push_back({rx_left, rx_right});
         pv   <= rx_valid & ~rx_ready;
         pdat <= {rx_left, rx_right};
      end else begin
         pv <= 1'b0;
      end
   end

   // expected captured word: n data bits, MSB-aligned, unfilled LSBs zero
   function automatic logic [W-1:0] rxw(input logic [31:0] w, input int n);
      logic [63:0] t;
      t = {32'd0, w};
      t = t & ((64'd1 << n) - 64'd1);
      t = t << (W - n);
      return t[W-1:0];
   endfunction

   task automatic sclk_cycle(input logic lr, input logic sd, output logic so);
      i2s_sclk  = 1'b0;
      i2s_lrclk = lr;
      i2s_sdin  = sd;
      repeat (4) @(posedge aclk);
      #1;
      so = i2s_sdout;
      i2s_sclk = 1'b1;
      repeat (4) @(posedge aclk);
      #1;
   endtask

   // one channel slot: switch bit, nbits data bits, extra filler bits
   task automatic send_half(input logic lr, input logic [31:0] word,
                            input int nbits, input int extra,
                            output logic [W-1:0] txw, output int tail);
      logic so, sd;
      txw  = '0;
      tail = 0;
      sclk_cycle(lr, 1'($urandom), so);
      for (int i = 0; i < nbits + extra; i++) begin
         sd = (i < nbits) ? word[nbits-1-i] : 1'($urandom);
         sclk_cycle(lr, sd, so);
         if (i < W) txw[W-1-i] = so;
         else if (so !== 1'b0) tail++;
      end
   endtask

   task automatic send_frame(input logic [31:0] l, input logic [31:0] r,
                             input int nbits, input int extra,
                             output logic [W-1:0] tl, output logic [W-1:0] tr,
                             output int tail);
      int t1, t2;
      send_half(1'b0, l, nbits, extra, tl, t1);
      send_half(1'b1, r, nbits, extra, tr, t2);
      tail = t1 + t2;
   endtask

   task automatic fill(input logic [W-1:0] l, input logic [W-1:0] r);
      tx_left  = l;
      tx_right = r;
      tx_valid = 1'b1;
      @(posedge aclk);
      #1;
      tx_valid = 1'b0;
   endtask

   task automatic do_reset();
      arstn     = 1'b0;
      i2s_sclk  = 1'b1;
      i2s_lrclk = 1'b0;
      tx_valid  = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      arstn = 1'b1;
      repeat (4) @(posedge aclk);
      #1;
   endtask

   task automatic start(input int nbits, input int extra);
      logic [W-1:0] d;
      int t;
      do_reset();
      send_half(1'b1, $urandom, nbits, extra, d, t);
   endtask

   task automatic test_reset();
      arstn = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      total++;
      if ({i2s_sdout, rx_valid, tx_ready, err_ovr, err_unr} !== 5'b00100) begin
         bad++;
         $display("FAIL reset_flags got=%b want=00100",
                  {i2s_sdout, rx_valid, tx_ready, err_ovr, err_unr});
      end
      total++;
      if ({rx_left, rx_right} !== '0) begin
         bad++;
         $display("FAIL reset_rxdata got=%h want=0", {rx_left, rx_right});
      end
      do_reset();
      total++;
      if ({i2s_sdout, rx_valid, tx_ready} !== 3'b001) begin
         bad++;
         $display("FAIL reset_release got=%b want=001",
                  {i2s_sdout, rx_valid, tx_ready});
      end
   endtask

   task automatic test_rx_basic();
      logic [W-1:0] tl, tr, l2, r2;
      int tail, base, vb;
      start(W, 7);
      base = got_q.size();
      vb   = vcyc;
      l2   = W'($urandom);
      r2   = W'($urandom);
      send_frame(32'hA5A5A5, 32'h123456, W, 7, tl, tr, tail);
      send_frame(32'(l2), 32'(r2), W, 7, tl, tr, tail);
      send_half(1'b0, $urandom, W, 7, tl, tail);
      total++;
      if (got_q.size() - base !== 2) begin
         bad++;
         $display("FAIL rx_count got=%0d want=2", got_q.size() - base);
      end else begin
         total++;
         if (got_q[base] !== {24'hA5A5A5, 24'h123456}) begin
            bad++;
            $display("FAIL rx_basic got=%h want=a5a5a5123456", got_q[base]);
         end
         total++;
         if (got_q[base+1] !== {l2, r2}) begin
            bad++;
            $display("FAIL rx_rand got=%h want=%h", got_q[base+1], {l2, r2});
         end
      end
      total++;
      if (vcyc - vb !== 2) begin
         bad++;
         $display("FAIL rx_valid_cycles got=%0d want=2", vcyc - vb);
      end
   endtask

   task automatic test_tx_basic();
      logic [W-1:0] tl, tr;
      int tail, ub;
      start(W, 7);
      ub = unr_n;
      total++;
      if (tx_ready !== 1'b1) begin
         bad++;
         $display("FAIL tx_ready_idle got=%b want=1", tx_ready);
      end
      fill(24'h800001, 24'h7FFFFF);
      total++;
      if (tx_ready !== 1'b0) begin
         bad++;
         $display("FAIL tx_ready_full got=%b want=0", tx_ready);
      end
      send_half(1'b0, $urandom, W, 7, tl, tail);
      total++;
      if (tx_ready !== 1'b1) begin
         bad++;
         $display("FAIL tx_ready_after_load got=%b want=1", tx_ready);
      end
      total++;
      if (tl !== 24'h800001 || tail !== 0) begin
         bad++;
         $display("FAIL tx_left got=%h tail=%0d want=800001 tail=0", tl, tail);
      end
      send_half(1'b1, $urandom, W, 7, tr, tail);
      total++;
      if (tr !== 24'h7FFFFF || tail !== 0) begin
         bad++;
         $display("FAIL tx_right got=%h tail=%0d want=7fffff tail=0", tr, tail);
      end
      total++;
      if (unr_n - ub !== 0) begin
         bad++;
         $display("FAIL tx_no_unr got=%0d want=0", unr_n - ub);
      end
   endtask

   task automatic test_back_to_back();
      logic [2*W-1:0] exp_q[$];
      logic [W-1:0] l, r, rl, rr, tl, tr;
      int tail, base, ob, ub, sb;
      start(W, 7);
      base = got_q.size();
      ob = ovr_n;
      ub = unr_n;
      sb = unstable;
      for (int k = 0; k < 5; k++) begin
         l  = W'($urandom);
         r  = W'($urandom);
         rl = W'($urandom);
         rr = W'($urandom);
         fill(l, r);
         send_frame(32'(rl), 32'(rr), W, 7, tl, tr, tail);
         exp_q.push_back({rl, rr});
         total++;
         if ({tl, tr} !== {l, r} || tail !== 0) begin
            bad++;
            $display("FAIL b2b_tx%0d got=%h want=%h tail=%0d", k, {tl, tr},
                     {l, r}, tail);
         end
      end
      send_half(1'b0, $urandom, W, 7, tl, tail);
      total++;
      if (got_q.size() - base !== exp_q.size()) begin
         bad++;
         $display("FAIL b2b_rx_count got=%0d want=%0d", got_q.size() - base,
                  exp_q.size());
      end else begin
         for (int k = 0; k < exp_q.size(); k++) begin
            total++;
            if (got_q[base+k] !== exp_q[k]) begin
               bad++;
               $display("FAIL b2b_rx%0d got=%h want=%h", k, got_q[base+k],
                        exp_q[k]);
            end
         end
      end
      total++;
      if (ovr_n - ob !== 0 || unr_n - ub !== 1 || unstable - sb !== 0) begin
         bad++;
         $display("FAIL b2b_errs got=%0d/%0d/%0d want=0/1/0", ovr_n - ob,
                  unr_n - ub, unstable - sb);
      end
   endtask

   task automatic test_overrun();
      logic [W-1:0] tl, tr;
      int tail, base, ob, sb;
      rx_ready = 1'b0;
      start(W, 7);
      base = got_q.size();
      ob = ovr_n;
      sb = unstable;
      send_frame(32'h000111, $urandom, W, 7, tl, tr, tail);
      send_frame(32'h000222, $urandom, W, 7, tl, tr, tail);
      send_half(1'b0, $urandom, W, 7, tl, tail);
      total++;
      if (rx_valid !== 1'b1 || rx_left !== 24'h000111) begin
         bad++;
         $display("FAIL ovr_keep got=%b/%h want=1/000111", rx_valid, rx_left);
      end
      total++;
      if (ovr_n - ob !== 1) begin
         bad++;
         $display("FAIL ovr_pulses got=%0d want=1", ovr_n - ob);
      end
      total++;
      if (unstable - sb !== 0) begin
         bad++;
         $display("FAIL ovr_stable got=%0d want=0", unstable - sb);
      end
      rx_ready = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      total++;
      if (got_q.size() - base !== 1 || rx_valid !== 1'b0) begin
         bad++;
         $display("FAIL ovr_drain got=%0d/%b want=1/0", got_q.size() - base,
                  rx_valid);
      end else begin
         total++;
         if (got_q[base][2*W-1:W] !== 24'h000111) begin
            bad++;
            $display("FAIL ovr_data got=%h want=000111", got_q[base][2*W-1:W]);
         end
      end
   endtask

   task automatic test_underrun();
      logic [W-1:0] r1, tl, tr;
      int tail, ub;
      start(W, 7);
      ub = unr_n;
      r1 = W'($urandom);
      fill(24'h0000FF, r1);
      send_frame($urandom, $urandom, W, 7, tl, tr, tail);
      total++;
      if ({tl, tr} !== {24'h0000FF, r1}) begin
         bad++;
         $display("FAIL unr_first got=%h want=%h", {tl, tr}, {24'h0000FF, r1});
      end
      send_frame($urandom, $urandom, W, 7, tl, tr, tail);
      total++;
      if (unr_n - ub !== 1) begin
         bad++;
         $display("FAIL unr_pulses got=%0d want=1", unr_n - ub);
      end
      total++;
      if ({tl, tr} !== (REP ? {24'h0000FF, r1} : 48'd0) || tail !== 0) begin
         bad++;
         $display("FAIL unr_data got=%h want=%h tail=%0d", {tl, tr},
                  (REP ? {24'h0000FF, r1} : 48'd0), tail);
      end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] tl, tr, fl, fr;
      logic so;
      int tail, base;
      start(W, 7);
      send_frame($urandom, $urandom, W, 7, tl, tr, tail);
      sclk_cycle(1'b0, 1'b1, so);
      for (int i = 0; i < 10; i++) sclk_cycle(1'b0, 1'($urandom), so);
      i2s_sclk = 1'b0;
      i2s_sdin = 1'($urandom);
      repeat (2) @(posedge aclk);
      #1;
      arstn = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      total++;
      if ({i2s_sdout, rx_valid, tx_ready, err_ovr, err_unr} !== 5'b00100 ||
          {rx_left, rx_right} !== '0) begin
         bad++;
         $display("FAIL mid_reset_out got=%b/%h want=00100/0",
                  {i2s_sdout, rx_valid, tx_ready, err_ovr, err_unr},
                  {rx_left, rx_right});
      end
      arstn = 1'b1;
      base = got_q.size();
      repeat (2) @(posedge aclk);
      #1;
      i2s_sclk = 1'b1;
      repeat (4) @(posedge aclk);
      #1;
      for (int i = 11; i < W + 7; i++) sclk_cycle(1'b0, 1'($urandom), so);
      send_half(1'b1, $urandom, W, 7, tr, tail);
      fl = W'($urandom);
      fr = W'($urandom);
      send_frame(32'(fl), 32'(fr), W, 7, tl, tr, tail);
      total++;
      if (got_q.size() - base !== 0) begin
         bad++;
         $display("FAIL mid_early_commit got=%0d want=0", got_q.size() - base);
      end
      send_half(1'b0, $urandom, W, 7, tl, tail);
      total++;
      if (got_q.size() - base !== 1) begin
         bad++;
         $display("FAIL mid_count got=%0d want=1", got_q.size() - base);
      end else begin
         total++;
         if (got_q[base] !== {fl, fr}) begin
            bad++;
            $display("FAIL mid_data got=%h want=%h", got_q[base], {fl, fr});
         end
      end
   endtask

   task automatic test_short_slot();
      logic [W-1:0] tl, tr;
      logic [31:0] r;
      int tail, base;
      start(16, 0);
      base = got_q.size();
      r = {16'd0, 16'($urandom)};
      send_frame(32'hBEEF, r, 16, 0, tl, tr, tail);
      send_half(1'b0, $urandom, 16, 0, tl, tail);
      total++;
      if (got_q.size() - base !== 1) begin
         bad++;
         $display("FAIL short_count got=%0d want=1", got_q.size() - base);
      end else begin
         total++;
         if (got_q[base] !== {rxw(32'hBEEF, 16), rxw(r, 16)}) begin
            bad++;
            $display("FAIL short_data got=%h want=%h", got_q[base],
                     {rxw(32'hBEEF, 16), rxw(r, 16)});
         end
      end
   endtask

   initial begin
      test_reset();
      test_rx_basic();
      test_tx_basic();
      test_back_to_back();
      test_overrun();
      test_underrun();
      test_reset_mid();
      test_short_slot();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
